gpr_file: RTL and testbench
===========================

# gpr_file

Parametrised general-purpose register file for the NPC core, with integrated busy-bit scoreboard. It provides two asynchronous read ports, one synchronous write port, and per-register pending-write tracking for multi-cycle producers such as loads and the multiplier. It sits between decode (reads, allocations) and writeback (writes), and exports a0 for the simulation exit and status check.

## Interface
Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; must be 16 (RV32E) or 32.
- AW, $clog2(NREGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wen  in  1  writeback enable.
- waddr  in  AW  writeback register index.
- wdata  in  XLEN  writeback data.
- raddr1  in  AW  read port 1 index.
- raddr2  in  AW  read port 2 index.
- rdata1  out  XLEN  read port 1 data, combinational.
- rdata2  out  XLEN  read port 2 data, combinational.
- alloc_en  in  1  decode marks a register as pending a future write.
- alloc_addr  in  AW  register index to mark busy.
- busy1  out  1  register raddr1 has a pending write.
- busy2  out  1  register raddr2 has a pending write.
- alloc_conflict  out  1  alloc targeted a register that is already busy (registered pulse).
- data_a0  out  XLEN  contents of register 10, combinational.

## Operation
- Storage: NREGS x XLEN flops plus NREGS busy bits. Index 0 is hard-wired: reads return 0, writes and allocs to 0 are ignored, and busy bit 0 is constantly 0.
- Write: when wen=1 and waddr!=0, reg[waddr] is set to wdata at the edge. The same edge clears busy[waddr].
- Alloc: when alloc_en=1 and alloc_addr!=0, busy[alloc_addr] is set at the edge.
- Alloc and write to the same register in the same cycle: busy stays 1, because the alloc belongs to a newer producer. The write data is still committed.
- Alloc to a register already busy and not being cleared this cycle: busy stays 1, and alloc_conflict=1 for exactly one cycle following. This is a protocol error, flagged and not blocked.
- Read: rdata1/rdata2 = reg[raddr], and busy1/busy2 = busy[raddr], both combinational. Same-cycle write behaviour depends on GPR_BYPASS_EN (see Configuration).
- Reset: while rst=1 at an edge, all registers, all busy bits and alloc_conflict are cleared to 0. This overrides any concurrent wen or alloc_en.
- When NREGS=16, the upper address bit is absent. data_a0 is valid in both configurations.

## Timing
- Read latency: 0 cycles (combinational from raddr).
- Write-to-read latency: 1 cycle without bypass; 0 cycles with bypass.
- busy set/clear: visible the cycle after the alloc_en or wen edge; 0 cycles for the clear when bypass is enabled.
- alloc_conflict: registered, asserted the cycle after the offending alloc.
- Output values after reset: rdata*=0, busy*=0, alloc_conflict=0, data_a0=0.

## Configuration
- GPR_BYPASS_EN defined:
  - If wen=1, waddr!=0 and waddr==raddrN, then rdataN=wdata and busyN=0 in the same cycle. The exception is a same-cycle alloc to that register, in which case busyN=1.
  - data_a0 also bypasses when waddr==10.
- GPR_BYPASS_EN undefined: reads see register contents only; the written value appears the next cycle.

## Structure
- Package gpr_pkg:
  - XLEN_DEFAULT=32.
  - NREGS_RV32I=32 and NREGS_RV32E=16.
  - REG_ZERO=0 and REG_A0=10.
- Sub-module gpr_scoreboard:
  - Holds the busy bits and alloc_conflict logic.
  - Inputs: clk, rst, wen, waddr, alloc_en, alloc_addr, raddr1, raddr2.
  - Outputs: busy1, busy2, alloc_conflict.
- The data array and bypass muxing stay in gpr_file.

## Test plan
- Reset, then read all indices → all rdata=0 and busy=0. Write x0=0xDEADBEEF → x0 still reads 0.
- Write x5=0x12345678, raddr1=5 the same cycle → rdata1=0x12345678 with bypass, 0 without. Next cycle → 0x12345678 in both builds.
- Alloc x7, then wait 3 cycles → busy1=1 for raddr1=7. Write x7=0xA5 → busy1 clears (same cycle with bypass, next cycle without) and rdata1=0xA5.
- Alloc x9 and write x9=0x1 in the same cycle → data committed, busy[9] stays 1. A second alloc to x9 → alloc_conflict pulses for 1 cycle.
- Write x10=0x0, then assert rst the same cycle as a write of x10=0x77 → data_a0=0 and all busy bits cleared.
- NREGS=16 build: write x15=0xFFFFFFFF and read it back → 0xFFFFFFFF. Write x10=42 → data_a0=42.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared constants for the NPC general-purpose register file.
package gpr_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int NREGS_RV32I  = 32;
  localparam int NREGS_RV32E  = 16;
  localparam int REG_ZERO     = 0;
  localparam int REG_A0       = 10;
endpackage

// File: rtl/gpr_scoreboard.sv
// Busy-bit scoreboard tracking registers with an outstanding multi-cycle write.
// Optional same-cycle writeback visibility on busy reads: GPR_BYPASS_EN.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NREGS = NREGS_RV32I,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wen,
  input  logic [AW-1:0] waddr,
  input  logic          alloc_en,
  input  logic [AW-1:0] alloc_addr,
  input  logic [AW-1:0] raddr1,
  input  logic [AW-1:0] raddr2,
  output logic          busy1,
  output logic          busy2,
  output logic          alloc_conflict
);

  logic [NREGS-1:0] busy_q, busy_d;
  logic             conflict_q, conflict_d;

  // Alloc is applied after the clear so a newer producer keeps the bit set.
  always_comb begin
    busy_d = busy_q;
    for (int i = 1; i < NREGS; i++) begin
      if (wen && (waddr == AW'(i)))           busy_d[i] = 1'b0;
      if (alloc_en && (alloc_addr == AW'(i))) busy_d[i] = 1'b1;
    end
    busy_d[REG_ZERO] = 1'b0;
    conflict_d = alloc_en && (alloc_addr != AW'(REG_ZERO)) && busy_q[alloc_addr]
                 && !(wen && (waddr == alloc_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q     <= '0;
      conflict_q <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      conflict_q <= conflict_d;
    end
  end

`ifdef GPR_BYPASS_EN
  logic hit1, hit2;

  always_comb begin
    hit1  = wen && (waddr != AW'(REG_ZERO)) && (waddr == raddr1);
    hit2  = wen && (waddr != AW'(REG_ZERO)) && (waddr == raddr2);
    busy1 = hit1 ? (alloc_en && (alloc_addr == raddr1)) : busy_q[raddr1];
    busy2 = hit2 ? (alloc_en && (alloc_addr == raddr2)) : busy_q[raddr2];
  end
`else
  always_comb begin
    busy1 = busy_q[raddr1];
    busy2 = busy_q[raddr2];
  end
`endif

  assign alloc_conflict = conflict_q;

endmodule

// File: rtl/gpr_file.sv
// NPC register file: 2 async read ports, 1 sync write port, busy scoreboard, a0 export.
// Optional write-to-read bypass: GPR_BYPASS_EN.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_RV32I,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wen,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            alloc_en,
  input  logic [AW-1:0]   alloc_addr,
  output logic            busy1,
  output logic            busy2,
  output logic            alloc_conflict,
  output logic [XLEN-1:0] data_a0
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] rd1_q, rd2_q, a0_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wen && (waddr != AW'(REG_ZERO))) begin
      regs_q[waddr] <= wdata;
    end
  end

  // x0 is forced to zero on read so it never depends on array contents.
  always_comb begin
    rd1_q = (raddr1 == AW'(REG_ZERO)) ? '0 : regs_q[raddr1];
    rd2_q = (raddr2 == AW'(REG_ZERO)) ? '0 : regs_q[raddr2];
    a0_q  = regs_q[REG_A0];
  end

`ifdef GPR_BYPASS_EN
  logic wr_live;

  always_comb begin
    wr_live = wen && (waddr != AW'(REG_ZERO));
    rdata1  = (wr_live && (waddr == raddr1)) ? wdata : rd1_q;
    rdata2  = (wr_live && (waddr == raddr2)) ? wdata : rd2_q;
    data_a0 = (wr_live && (waddr == AW'(REG_A0))) ? wdata : a0_q;
  end
`else
  always_comb begin
    rdata1  = rd1_q;
    rdata2  = rd2_q;
    data_a0 = a0_q;
  end
`endif

  gpr_scoreboard #(
    .NREGS (NREGS),
    .AW    (AW)
  ) u_sb (
    .clk            (clk),
    .rst            (rst),
    .wen            (wen),
    .waddr          (waddr),
    .alloc_en       (alloc_en),
    .alloc_addr     (alloc_addr),
    .raddr1         (raddr1),
    .raddr2         (raddr2),
    .busy1          (busy1),
    .busy2          (busy2),
    .alloc_conflict (alloc_conflict)
  );

endmodule

// File: tb/tb_gpr_file.sv
// Directed bench for gpr_file: RV32I instance plus an RV32E (NREGS=16) instance.
module tb_gpr_file;
  localparam int XLEN = 32;

`ifdef GPR_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // RV32I instance
  logic            wen, alloc_en, busy1, busy2, alloc_conflict;
  logic [4:0]      waddr, raddr1, raddr2, alloc_addr;
  logic [XLEN-1:0] wdata, rdata1, rdata2, data_a0;

  // RV32E instance
  logic            e_wen, e_alloc_en, e_busy1, e_busy2, e_conflict;
  logic [3:0]      e_waddr, e_raddr1, e_raddr2, e_alloc_addr;
  logic [XLEN-1:0] e_wdata, e_rdata1, e_rdata2, e_a0;

  int total = 0;
  int bad   = 0;

  gpr_file #(.XLEN(XLEN), .NREGS(32)) u_dut (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1), .rdata2(rdata2),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy1(busy1), .busy2(busy2),
    .alloc_conflict(alloc_conflict), .data_a0(data_a0)
  );

  gpr_file #(.XLEN(XLEN), .NREGS(16)) u_dut_e (
    .clk(clk), .rst(rst), .wen(e_wen), .waddr(e_waddr), .wdata(e_wdata),
    .raddr1(e_raddr1), .raddr2(e_raddr2), .rdata1(e_rdata1), .rdata2(e_rdata2),
    .alloc_en(e_alloc_en), .alloc_addr(e_alloc_addr), .busy1(e_busy1), .busy2(e_busy2),
    .alloc_conflict(e_conflict), .data_a0(e_a0)
  );

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change 1ns after it, outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    wen = 0; waddr = 0; wdata = 0; raddr1 = 0; raddr2 = 0; alloc_en = 0; alloc_addr = 0;
    e_wen = 0; e_waddr = 0; e_wdata = 0; e_raddr1 = 0; e_raddr2 = 0;
    e_alloc_en = 0; e_alloc_addr = 0;
    tick(); tick();
    rst = 1'b0;
    #1;

    // Reset state on every index
    for (int i = 0; i < 32; i++) begin
      raddr1 = 5'(i); raddr2 = 5'(31 - i);
      #1;
      check($sformatf("rst_rd1_x%0d", i), rdata1, '0);
      check($sformatf("rst_rd2_x%0d", 31 - i), rdata2, '0);
      check($sformatf("rst_busy1_x%0d", i), {31'b0, busy1}, '0);
      check($sformatf("rst_busy2_x%0d", 31 - i), {31'b0, busy2}, '0);
    end
    check("rst_a0", data_a0, '0);
    check("rst_conflict", {31'b0, alloc_conflict}, '0);

    // x0 is hard-wired
    tick();
    wen = 1; waddr = 0; wdata = 32'hDEADBEEF; raddr1 = 0; alloc_en = 1; alloc_addr = 0;
    #1;
    check("x0_wr_same", rdata1, '0);
    tick();
    wen = 0; alloc_en = 0;
    #1;
    check("x0_wr_next", rdata1, '0);
    check("x0_busy", {31'b0, busy1}, '0);

    // Write x5, read same cycle and next cycle
    wen = 1; waddr = 5; wdata = 32'h12345678; raddr1 = 5; raddr2 = 6;
    #1;
    check("x5_same", rdata1, BYP ? 32'h12345678 : 32'h0);
    check("x6_untouched", rdata2, '0);
    tick();
    wen = 0;
    #1;
    check("x5_next", rdata1, 32'h12345678);

    // Alloc x7, wait, then write it back
    alloc_en = 1; alloc_addr = 7; raddr1 = 7;
    #1;
    check("x7_busy_same_alloc", {31'b0, busy1}, '0);
    tick();
    alloc_en = 0;
    tick(); tick(); tick();
    check("x7_busy", {31'b0, busy1}, 32'd1);
    check("x7_no_conflict", {31'b0, alloc_conflict}, '0);
    wen = 1; waddr = 7; wdata = 32'hA5;
    #1;
    check("x7_busy_wb_same", {31'b0, busy1}, BYP ? 32'd0 : 32'd1);
    check("x7_rd_wb_same", rdata1, BYP ? 32'hA5 : 32'h0);
    tick();
    wen = 0;
    #1;
    check("x7_busy_wb_next", {31'b0, busy1}, '0);
    check("x7_rd_wb_next", rdata1, 32'hA5);

    // Alloc and write x9 together: newer producer keeps busy set
    alloc_en = 1; alloc_addr = 9; wen = 1; waddr = 9; wdata = 32'h1; raddr2 = 9;
    #1;
    check("x9_busy_same", {31'b0, busy2}, BYP ? 32'd1 : 32'd0);
    check("x9_rd_same", rdata2, BYP ? 32'h1 : 32'h0);
    tick();
    alloc_en = 0; wen = 0;
    #1;
    check("x9_busy_next", {31'b0, busy2}, 32'd1);
    check("x9_rd_next", rdata2, 32'h1);
    check("x9_no_conflict", {31'b0, alloc_conflict}, '0);

    // Second alloc on busy x9 -> one-cycle conflict pulse
    alloc_en = 1; alloc_addr = 9;
    #1;
    check("conflict_not_early", {31'b0, alloc_conflict}, '0);
    tick();
    alloc_en = 0;
    #1;
    check("conflict_pulse", {31'b0, alloc_conflict}, 32'd1);
    check("x9_still_busy", {31'b0, busy2}, 32'd1);
    tick();
    check("conflict_drop", {31'b0, alloc_conflict}, '0);

    // Re-alloc of busy x9 while it is being cleared is not a conflict
    alloc_en = 1; alloc_addr = 9; wen = 1; waddr = 9; wdata = 32'h2;
    tick();
    alloc_en = 0; wen = 0;
    #1;
    check("realloc_clear_no_conflict", {31'b0, alloc_conflict}, '0);
    check("realloc_busy", {31'b0, busy2}, 32'd1);
    check("realloc_data", rdata2, 32'h2);

    // a0 export, then reset overriding a concurrent write and alloc
    wen = 1; waddr = 10; wdata = 32'h55;
    #1;
    check("a0_same", data_a0, BYP ? 32'h55 : 32'h0);
    tick();
    wen = 0;
    #1;
    check("a0_next", data_a0, 32'h55);
    wen = 1; waddr = 10; wdata = 32'h0;
    tick();
    check("a0_zero", data_a0, BYP ? 32'h0 : 32'h0);
    alloc_en = 1; alloc_addr = 11; wdata = 32'h77; rst = 1;
    tick();
    rst = 0; wen = 0; alloc_en = 0; raddr1 = 11; raddr2 = 9;
    #1;
    check("rst_a0_after", data_a0, '0);
    check("rst_x11_busy", {31'b0, busy1}, '0);
    check("rst_x9_busy", {31'b0, busy2}, '0);
    check("rst_x9_data", rdata2, '0);
    raddr1 = 5; raddr2 = 7;
    #1;
    check("rst_x5_data", rdata1, '0);
    check("rst_x7_data", rdata2, '0);

    // RV32E instance
    e_wen = 1; e_waddr = 15; e_wdata = 32'hFFFFFFFF; e_raddr1 = 15; e_raddr2 = 14;
    tick();
    e_wen = 0;
    #1;
    check("e_x15", e_rdata1, 32'hFFFFFFFF);
    check("e_x14", e_rdata2, '0);
    e_wen = 1; e_waddr = 10; e_wdata = 32'd42;
    tick();
    e_wen = 0;
    #1;
    check("e_a0", e_a0, 32'd42);
    e_alloc_en = 1; e_alloc_addr = 15;
    tick();
    e_alloc_en = 0;
    #1;
    check("e_x15_busy", {31'b0, e_busy1}, 32'd1);
    check("e_x14_busy", {31'b0, e_busy2}, '0);
    check("e_conflict", {31'b0, e_conflict}, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
